lz77_match_sched: RTL and testbench
===================================

# lz77_match_sched

Sequencer for the LZ77 match-candidate path. It latches a 64-bit match bitmap from the hash/compare stage and drives a lowest-set-bit detector (result = index+1, or 65 when the bitmap is empty) on a registered copy of that bitmap. It emits one candidate window position per cycle to the match-length engine over a valid/ready handshake, clearing each bit as it is accepted. A programmable limit caps how many candidates are emitted per search.

## Interface
- `ADR_WD`, 16: width of window positions (`base_i`, `cand_pos_o`).
- `CNT_WD`, 7: width of the candidate counter (must hold 64).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start_i`  in  1  one-cycle request; sampled only in IDLE.
- `map_i`  in  64  match bitmap; bit k set means window offset k is a candidate.
- `base_i`  in  ADR_WD  window position of bitmap bit 0.
- `lim_i`  in  CNT_WD  maximum candidates per search; 0 means unlimited (64).
- `flush_i`  in  1  abort; highest priority.
- `cand_val_o`  out  1  candidate valid.
- `cand_rdy_i`  in  1  consumer ready.
- `cand_pos_o`  out  ADR_WD  candidate position.
- `cand_last_o`  out  1  final candidate of this search; qualified by `cand_val_o`.
- `busy_o`  out  1  high in SCAN and DONE.
- `done_o`  out  1  one-cycle end-of-search pulse.
- `cnt_o`  out  CNT_WD  candidates accepted in the current or last search; held until the next start.

## Operation
- FSM with three states: IDLE, SCAN, DONE. Registers: `map_r`[63:0], `base_r`, `cnt_r`, `lim_r`.
- **IDLE**: on `start_i`, latch `map_r`, `base_r` and `lim_r`, clear `cnt_r`, then move to SCAN. If `map_i==0`, move straight to DONE instead.
- **SCAN**:
  - The detector output `p` is computed from `map_r`.
  - `cand_val_o = (map_r != 0)`.
  - `cand_pos_o = base_r + (p - 1)`, truncated to ADR_WD bits (wraps modulo 2^ADR_WD).
- **Handshake**: when `cand_val_o && cand_rdy_i`, clear bit `p-1` of `map_r` and increment `cnt_r`.
- **Last candidate**: `cand_last_o = 1` when the cleared map would be 0, or when `cnt_r + 1 == lim_r` (with `lim_r != 0`).
  - A handshake with `cand_last_o` moves the FSM to DONE.
  - If `lim_r` is reached before the map empties, the remaining bits are discarded.
- **DONE**: `done_o = 1` for exactly one cycle, then return to IDLE. `cnt_o` reflects the final count.
- **Stalls**: while `cand_rdy_i` is low, `cand_val_o`, `cand_pos_o` and `cand_last_o` stay stable.
- **Ignored starts**: `start_i` in SCAN or DONE is dropped, with no queuing.
- **Flush**: `flush_i` in any state moves the FSM to IDLE on the next edge and clears `map_r`. No `done_o` is produced, and `cnt_o` keeps its value. In the flush cycle `cand_val_o` may be high, but a handshake in that cycle does not count. `flush_i` together with `start_i` in IDLE: flush wins and the start is dropped.
- **Reset values**: state=IDLE, `map_r=0`, `cnt_r=0`, `cand_val_o=0`, `cand_last_o=0`, `cand_pos_o=0` (since `base_r=0` and the detector sees 0, the wrapped result is forced to 0), `busy_o=0`, `done_o=0`, `cnt_o=0`.

## Timing
- `start_i` in cycle N gives `cand_val_o` in cycle N+1.
- Throughput is one candidate per cycle while `cand_rdy_i` stays high.
- A last handshake in cycle M gives `done_o` in M+1 and IDLE in M+2. The earliest next `start_i` is accepted in M+2.
- Empty map: `start_i` in N gives `done_o` in N+1 with `cnt_o=0` and no `cand_val_o`.
- The critical path is `map_r` → detector → adder → `cand_pos_o`. All outputs except `cand_pos_o` and `cand_last_o` are registered or decoded from state.
- Asynchronous `rst` mid-search forces the reset values immediately and discards the search.

## Test plan
- `map_i=64'h8000_0000_0000_0011`, `base_i=100`, `lim_i=0`, rdy always high → positions 100, 104, 163 in consecutive cycles; last on 163; `done_o` next cycle; `cnt_o=3`.
- `map_i=0`, `start_i` at N → `done_o` at N+1, `cnt_o=0`, `cand_val_o` never high.
- `map_i=64'hFFFF_FFFF_FFFF_FFFF`, `base_i=16'hFFF0`, `lim_i=4` → positions FFF0, FFF1, FFF2, FFF3, last on FFF3, `cnt_o=4`. Repeat with `lim_i=0` → 64 candidates, wrap from 16'hFFFF to 16'h0000, last on 16'h002F.
- `map_i=64'h5`, rdy low for 3 cycles then high → `cand_pos_o=base` held stable while stalled; then base, base+2; a second `start_i` during SCAN is ignored.
- Flush during SCAN after 1 accept, with `map_i=64'hF0` → IDLE next cycle, no `done_o`, `cnt_o=1`. `flush_i` together with `start_i` in IDLE → stays IDLE.
- Assert `rst` mid-search → all outputs at reset values in the same cycle. A new search after release runs correctly.

Source files
------------

// File: rtl/lz77_match_sched_if.sv
// lz77_match_sched_if
// Groups every non-clock/reset signal of the LZ77 match-candidate sequencer.
//   start, map, base, lim, flush : search request and control (into the scheduler)
//   cand_val, cand_rdy, cand_pos,
//   cand_last                    : candidate stream to the match-length engine
//   busy, done, cnt              : status (out of the scheduler)
// The slave modport is the scheduler's view; master is the requester/consumer view.
interface lz77_match_sched_if #(
  parameter int ADR_WD = 16,
  parameter int CNT_WD = 7
);
  logic              start;
  logic [63:0]       map;
  logic [ADR_WD-1:0] base;
  logic [CNT_WD-1:0] lim;
  logic              flush;
  logic              cand_val;
  logic              cand_rdy;
  logic [ADR_WD-1:0] cand_pos;
  logic              cand_last;
  logic              busy;
  logic              done;
  logic [CNT_WD-1:0] cnt;

  modport slave (
    input  start, map, base, lim, flush, cand_rdy,
    output cand_val, cand_pos, cand_last, busy, done, cnt
  );

  modport master (
    output start, map, base, lim, flush, cand_rdy,
    input  cand_val, cand_pos, cand_last, busy, done, cnt
  );
endinterface

// File: rtl/lz77_match_sched.sv
// lz77_match_sched
// Latches a 64-bit match bitmap and streams one candidate window position per
// cycle (lowest set bit first) over a valid/ready handshake, clearing each bit
// as it is accepted. A programmable limit caps the candidates per search.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - lz77_match_sched_if.slave (request, candidate stream, status)
module lz77_match_sched #(
  parameter int ADR_WD = 16,
  parameter int CNT_WD = 7
) (
  input logic                clk,
  input logic                rst,
  lz77_match_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state;
  logic [63:0]       map_r;
  logic [ADR_WD-1:0] base_r;
  logic [CNT_WD-1:0] cnt_r;
  logic [CNT_WD-1:0] lim_r;

  logic [6:0]        p;
  logic [63:0]       map_next;
  logic              hit;
  logic              last;

  // Lowest-set-bit detector: index+1 of the lowest set bit, 65 when empty.
  // Scanning from the top down lets the lowest set bit win.
  always_comb begin
    p = 7'd65;
    for (int i = 63; i >= 0; i--) begin
      if (map_r[i]) p = 7'(i + 1);
    end
  end

  // x & (x-1) clears exactly the lowest set bit, i.e. bit p-1.
  // The last flag fires when the map would empty or the limit would be reached.
  always_comb begin
    map_next = map_r & (map_r - 64'd1);
    hit      = (state == SCAN) && (map_r != 64'd0);
    last     = hit && ((map_next == 64'd0) ||
                       ((lim_r != '0) && (CNT_WD'(cnt_r + CNT_WD'(1)) == lim_r)));
  end

  // Main sequencer. Flush overrides everything except reset and discards the
  // map without touching the count. Remaining bits are dropped when a search
  // ends early on the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      map_r  <= '0;
      base_r <= '0;
      cnt_r  <= '0;
      lim_r  <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
      map_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            map_r  <= bus.map;
            base_r <= bus.base;
            lim_r  <= bus.lim;
            cnt_r  <= '0;
            state  <= (bus.map == 64'd0) ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (hit && bus.cand_rdy) begin
            cnt_r <= cnt_r + CNT_WD'(1);
            if (last) begin
              map_r <= '0;
              state <= DONE;
            end else begin
              map_r <= map_next;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Position is forced to 0 when the map is empty so the reset value is clean.
  assign bus.cand_pos  = (map_r != 64'd0) ? base_r + ADR_WD'(p - 7'd1) : '0;
  assign bus.cand_val  = hit;
  assign bus.cand_last = last;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.cnt       = cnt_r;

endmodule

// File: tb/tb_lz77_match_sched.sv
// tb_lz77_match_sched
// Directed testbench for lz77_match_sched with hand-computed expectations.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_lz77_match_sched;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  lz77_match_sched_if #(.ADR_WD(16), .CNT_WD(7)) bus ();

  lz77_match_sched #(.ADR_WD(16), .CNT_WD(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset values while rst is held
  task automatic test_reset();
    checks++; if (bus.cand_val !== 1'b0) $display("[TB] FAIL reset_val: got %b expected 0", bus.cand_val); else passes++;
    checks++; if (bus.cand_last !== 1'b0) $display("[TB] FAIL reset_last: got %b expected 0", bus.cand_last); else passes++;
    checks++; if (bus.cand_pos !== 16'h0000) $display("[TB] FAIL reset_pos: got %h expected 0000", bus.cand_pos); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); else passes++;
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus.done); else passes++;
    checks++; if (bus.cnt !== 7'd0) $display("[TB] FAIL reset_cnt: got %0d expected 0", bus.cnt); else passes++;
  endtask

  // Sparse map: bits 0, 4, 63 from base 100
  task automatic test_basic();
    logic [15:0] exp_pos [3];
    exp_pos[0] = 16'd100; exp_pos[1] = 16'd104; exp_pos[2] = 16'd163;
    bus.map = 64'h8000_0000_0000_0011; bus.base = 16'd100; bus.lim = 7'd0;
    bus.cand_rdy = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.cand_val !== 1'b1) $display("[TB] FAIL basic_val%0d: got %b expected 1", k, bus.cand_val); else passes++;
      checks++; if (bus.cand_pos !== exp_pos[k]) $display("[TB] FAIL basic_pos%0d: got %0d expected %0d", k, bus.cand_pos, exp_pos[k]); else passes++;
      checks++; if (bus.cand_last !== (k == 2)) $display("[TB] FAIL basic_last%0d: got %b expected %b", k, bus.cand_last, (k == 2)); else passes++;
      tick();
    end
    checks++; if (bus.done !== 1'b1) $display("[TB] FAIL basic_done: got %b expected 1", bus.done); else passes++;
    checks++; if (bus.cnt !== 7'd3) $display("[TB] FAIL basic_cnt: got %0d expected 3", bus.cnt); else passes++;
    checks++; if (bus.cand_val !== 1'b0) $display("[TB] FAIL basic_val_done: got %b expected 0", bus.cand_val); else passes++;
    tick();
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL basic_done_pulse: got %b expected 0", bus.done); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL basic_idle: got %b expected 0", bus.busy); else passes++;
  endtask

  // Empty map goes straight to DONE
  task automatic test_empty();
    bus.map = 64'd0; bus.base = 16'd7; bus.lim = 7'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.done !== 1'b1) $display("[TB] FAIL empty_done: got %b expected 1", bus.done); else passes++;
    checks++; if (bus.cand_val !== 1'b0) $display("[TB] FAIL empty_val: got %b expected 0", bus.cand_val); else passes++;
    checks++; if (bus.cnt !== 7'd0) $display("[TB] FAIL empty_cnt: got %0d expected 0", bus.cnt); else passes++;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.cand_val !== 1'b0) $display("[TB] FAIL empty_idle: got busy=%b val=%b expected busy=0 val=0", bus.busy, bus.cand_val); else passes++;
  endtask

  // Full map with a limit, then unlimited (wraps through FFFF -> 0000)
  task automatic test_limit(input logic [6:0] lim, input int n);
    logic [15:0] exp;
    bus.map = 64'hFFFF_FFFF_FFFF_FFFF; bus.base = 16'hFFF0; bus.lim = lim;
    bus.cand_rdy = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < n; k++) begin
      exp = 16'hFFF0 + 16'(k);
      checks++; if (bus.cand_val !== 1'b1 || bus.cand_pos !== exp) $display("[TB] FAIL limit%0d_pos%0d: got val=%b pos=%h expected val=1 pos=%h", lim, k, bus.cand_val, bus.cand_pos, exp); else passes++;
      checks++; if (bus.cand_last !== (k == n - 1)) $display("[TB] FAIL limit%0d_last%0d: got %b expected %b", lim, k, bus.cand_last, (k == n - 1)); else passes++;
      tick();
    end
    checks++; if (bus.done !== 1'b1 || bus.cand_val !== 1'b0) $display("[TB] FAIL limit%0d_done: got done=%b val=%b expected done=1 val=0", lim, bus.done, bus.cand_val); else passes++;
    checks++; if (bus.cnt !== 7'(n)) $display("[TB] FAIL limit%0d_cnt: got %0d expected %0d", lim, bus.cnt, n); else passes++;
    tick();
  endtask

  // Stall with rdy low, plus an ignored start during SCAN
  task automatic test_stall();
    bus.map = 64'h5; bus.base = 16'd200; bus.lim = 7'd0;
    bus.cand_rdy = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.cand_val !== 1'b1 || bus.cand_pos !== 16'd200 || bus.cand_last !== 1'b0) $display("[TB] FAIL stall_hold%0d: got val=%b pos=%0d last=%b expected val=1 pos=200 last=0", k, bus.cand_val, bus.cand_pos, bus.cand_last); else passes++;
      if (k == 0) begin
        bus.start = 1'b1; bus.map = 64'hFF00; bus.base = 16'd0;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.cand_rdy = 1'b1;
    checks++; if (bus.cand_pos !== 16'd200 || bus.cand_last !== 1'b0) $display("[TB] FAIL stall_first: got pos=%0d last=%b expected pos=200 last=0", bus.cand_pos, bus.cand_last); else passes++;
    tick();
    checks++; if (bus.cand_pos !== 16'd202 || bus.cand_last !== 1'b1) $display("[TB] FAIL stall_second: got pos=%0d last=%b expected pos=202 last=1", bus.cand_pos, bus.cand_last); else passes++;
    tick();
    checks++; if (bus.done !== 1'b1 || bus.cnt !== 7'd2) $display("[TB] FAIL stall_done: got done=%b cnt=%0d expected done=1 cnt=2", bus.done, bus.cnt); else passes++;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.cand_val !== 1'b0) $display("[TB] FAIL stall_no_queue: got busy=%b val=%b expected busy=0 val=0", bus.busy, bus.cand_val); else passes++;
  endtask

  // Flush mid-search, then flush together with start in IDLE
  task automatic test_flush();
    bus.map = 64'hF0; bus.base = 16'd0; bus.lim = 7'd0;
    bus.cand_rdy = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.cand_pos !== 16'd4) $display("[TB] FAIL flush_pos0: got %0d expected 4", bus.cand_pos); else passes++;
    tick();
    checks++; if (bus.cand_pos !== 16'd5) $display("[TB] FAIL flush_pos1: got %0d expected 5", bus.cand_pos); else passes++;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.cand_val !== 1'b0 || bus.done !== 1'b0) $display("[TB] FAIL flush_idle: got busy=%b val=%b done=%b expected 0 0 0", bus.busy, bus.cand_val, bus.done); else passes++;
    checks++; if (bus.cnt !== 7'd1) $display("[TB] FAIL flush_cnt: got %0d expected 1", bus.cnt); else passes++;
    tick();
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL flush_no_done: got %b expected 0", bus.done); else passes++;
    bus.map = 64'h1; bus.start = 1'b1; bus.flush = 1'b1;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.cand_val !== 1'b0 || bus.cnt !== 7'd1) $display("[TB] FAIL flush_start: got busy=%b val=%b cnt=%0d expected busy=0 val=0 cnt=1", bus.busy, bus.cand_val, bus.cnt); else passes++;
  endtask

  // Asynchronous reset mid-search, then a clean search afterwards
  task automatic test_async_reset();
    bus.map = 64'hF; bus.base = 16'd10; bus.lim = 7'd0;
    bus.cand_rdy = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.cand_val !== 1'b1 || bus.cand_pos !== 16'd10) $display("[TB] FAIL arst_pre: got val=%b pos=%0d expected val=1 pos=10", bus.cand_val, bus.cand_pos); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.cand_val !== 1'b0 || bus.cand_pos !== 16'd0 || bus.cand_last !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cnt !== 7'd0) $display("[TB] FAIL arst_now: got val=%b pos=%h last=%b busy=%b done=%b cnt=%0d expected all 0", bus.cand_val, bus.cand_pos, bus.cand_last, bus.busy, bus.done, bus.cnt); else passes++;
    tick();
    rst = 1'b0;
    bus.map = 64'h3; bus.base = 16'd50; bus.cand_rdy = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.cand_pos !== 16'd50 || bus.cand_last !== 1'b0) $display("[TB] FAIL arst_pos0: got pos=%0d last=%b expected pos=50 last=0", bus.cand_pos, bus.cand_last); else passes++;
    tick();
    checks++; if (bus.cand_pos !== 16'd51 || bus.cand_last !== 1'b1) $display("[TB] FAIL arst_pos1: got pos=%0d last=%b expected pos=51 last=1", bus.cand_pos, bus.cand_last); else passes++;
    tick();
    checks++; if (bus.done !== 1'b1 || bus.cnt !== 7'd2) $display("[TB] FAIL arst_done: got done=%b cnt=%0d expected done=1 cnt=2", bus.done, bus.cnt); else passes++;
    tick();
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.map = '0; bus.base = '0; bus.lim = '0;
    bus.flush = 1'b0; bus.cand_rdy = 1'b0;
    #3;
    test_reset();
    tick();
    rst = 1'b0;
    tick();
    test_basic();
    test_empty();
    test_limit(7'd4, 4);
    test_limit(7'd0, 64);
    test_stall();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
